dmem_responder: RTL and testbench

- Data-memory responder for the MIPS pipeline CPU. The CPU load/store stage is the initiator; this block is the target end of the same request/acknowledge interface.
- Accepts one word request at a time and inserts a programmable number of wait states, so the pipeline's stall logic gets exercised.
- Returns load data or commits store data with byte-lane granularity, and flags illegal accesses.
- Sits between the CPU MEM stage and the word-organised data RAM.

---
 rtl/mips_mem_pkg.sv | 36 +++
 rtl/dmem_ram.sv | 30 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: responder FSM states,
// byte-lane constants and the CPU-side request record.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int BYTE_OFF_W = 2;
  localparam int REQ_ADDR_W = 32;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } mem_req_t;

  // Width of a word index into a RAM of the given depth.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < BE_W; i++) mask[8*i +: 8] = {8{be[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port data RAM with per-byte write enables and a
// registered read port (one cycle from index to data).
module dmem_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [BE_W-1:0]   wen_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset on purpose; a reset would force the whole
  // array into flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wen_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Target side of the MEM-stage request/ack handshake: accepts one access,
// waits LATENCY cycles, then acks with load data or commits the store.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bad_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic              idx_oob;
  logic              req_bad;
  logic [IDX_W-1:0]  ram_idx;
  logic [BE_W-1:0]   ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] resp_data;

  assign idx_oob = {2'b00, addr[ADDR_W-1:BYTE_OFF_W]} >= ADDR_W'(DEPTH);
  assign req_bad = idx_oob || (be == '0) ||
                   ((addr[BYTE_OFF_W-1:0] != '0) && (be == BE_WORD));

  // The RAM reads the live address while idle so its registered read lands
  // in the RESP cycle even when LATENCY is 1.
  assign ram_idx = (state_q == IDLE) ? addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W] : idx_q;
  assign ram_wen = (state_q == RESP && we_q && !bad_q && !rst) ? be_q : '0;

  dmem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .idx_i   (ram_idx),
    .wen_i   (ram_wen),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Stores leave rdata untouched; errors zero it.
  assign resp_data = err_q ? '0 :
                     we_q  ? rdata_q : (ram_rdata & be_to_mask(be_q));
  assign rdata     = ack_q ? resp_data : rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;

  // NOTE: every register here is assigned with <= so all reads in this block
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (ack_q) rdata_q <= resp_data;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            be_q    <= be;
            idx_q   <= addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
            wdata_q <= wdata;
            bad_q   <= req_bad;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            if (LATENCY == 1) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= req_bad;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q <= CNT_ONE) begin
            state_q <= RESP;
            cnt_q   <= '0;
            ack_q   <= 1'b1;
            err_q   <= bad_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 2, 1 and 4,
// directed vectors queued at issue time and checked by a negedge monitor.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  localparam int LAT [3] = '{2, 1, 4};

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
    int          edge_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v   [3];
  logic        we_v    [3];
  logic [3:0]  be_v    [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        ack_v   [3];
  logic        err_v   [3];
  logic        busy_v  [3];
  logic [31:0] rdata_v [3];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [3][$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .be(be_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .ack(ack_v[0]), .err(err_v[0]),
    .rdata(rdata_v[0]), .busy(busy_v[0]));

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .be(be_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ack(ack_v[1]), .err(err_v[1]),
    .rdata(rdata_v[1]), .busy(busy_v[1]));

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .be(be_v[2]),
    .addr(addr_v[2]), .wdata(wdata_v[2]), .ack(ack_v[2]), .err(err_v[2]),
    .rdata(rdata_v[2]), .busy(busy_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_t mk(input logic w, input logic [3:0] b,
                                  input logic [31:0] a, input logic [31:0] d);
    mem_req_t r;
    r.we = w; r.be = b; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Entered just after a rising edge; returns just after the edge that ends
  // the ack cycle. hold=1 keeps req high so the next call is back-to-back.
  task automatic issue(input int k, input mem_req_t r, input logic e_err,
                       input logic [31:0] e_rd, input bit hold);
    exp_t e;
    bit   saw;
    int   n;
    req_v[k] = 1'b1; we_v[k] = r.we; be_v[k] = r.be;
    addr_v[k] = r.addr; wdata_v[k] = r.wdata;
    e.err = e_err; e.rdata = e_rd; e.chk_rd = !r.we || e_err;
    e.edge_cyc = cyc + 1 + LAT[k];
    sb[k].push_back(e);
    saw = 1'b0; n = 0;
    while (!saw && n < 64) begin
      @(negedge clk);
      if (ack_v[k] === 1'b1) saw = 1'b1;
      n++;
    end
    check($sformatf("ack_seen_i%0d_a%h", k, r.addr), {31'b0, saw}, 32'd1);
    if (saw) check($sformatf("busy_at_ack_i%0d", k), {31'b0, busy_v[k]}, 32'd1);
    @(posedge clk); #1;
    if (!hold) req_v[k] = 1'b0;
    check($sformatf("busy_after_ack_i%0d", k), {31'b0, busy_v[k]}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on every ack and checks timing and data.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ack_v[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          check($sformatf("unexpected_ack_i%0d", k), {31'b0, ack_v[k]}, 32'd0);
        end else begin
          e = sb[k].pop_front();
          check($sformatf("ack_edge_i%0d", k), cyc + 1, e.edge_cyc);
          check($sformatf("err_i%0d", k), {31'b0, err_v[k]}, {31'b0, e.err});
          if (e.chk_rd) check($sformatf("rdata_i%0d", k), rdata_v[k], e.rdata);
        end
      end else if (err_v[k] !== 1'b0) begin
        check($sformatf("err_without_ack_i%0d", k), {31'b0, err_v[k]}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] model [16];
    int          idx;
    logic        w;
    logic [3:0]  b;
    logic [31:0] d;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; be_v[k] = 4'h0;
      addr_v[k] = 32'h0; wdata_v[k] = 32'h0;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ack_i%0d", k), {31'b0, ack_v[k]}, 32'd0);
      check($sformatf("reset_err_i%0d", k), {31'b0, err_v[k]}, 32'd0);
      check($sformatf("reset_busy_i%0d", k), {31'b0, busy_v[k]}, 32'd0);
      check($sformatf("reset_rdata_i%0d", k), rdata_v[k], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load at LATENCY 2, then rdata must hold after ack.
    issue(0, mk(1'b1, 4'hF, 32'h10, 32'hDEADBEEF), 1'b0, 32'h0, 1'b0);
    issue(0, mk(1'b0, 4'hF, 32'h10, 32'h0), 1'b0, 32'hDEADBEEF, 1'b0);
    check("rdata_hold_after_load", rdata_v[0], 32'hDEADBEEF);

    // Byte-lane merge and sub-word load.
    issue(0, mk(1'b1, 4'hF, 32'h20, 32'h11223344), 1'b0, 32'h0, 1'b0);
    issue(0, mk(1'b1, 4'b0100, 32'h20, 32'h00AA0000), 1'b0, 32'h0, 1'b0);
    issue(0, mk(1'b0, 4'hF, 32'h20, 32'h0), 1'b0, 32'h11AA3344, 1'b0);
    issue(0, mk(1'b0, 4'b0001, 32'h20, 32'h0), 1'b0, 32'h00000044, 1'b0);
    issue(0, mk(1'b1, 4'hF, 32'h24, 32'h01020304), 1'b0, 32'h0, 1'b0);
    check("rdata_hold_after_store", rdata_v[0], 32'h00000044);

    // Error responses and the last legal word.
    issue(0, mk(1'b0, 4'hF, 32'h1000, 32'h0), 1'b1, 32'h0, 1'b0);
    check("rdata_zero_after_err", rdata_v[0], 32'h0);
    issue(0, mk(1'b1, 4'hF, 32'h22, 32'hFFFFFFFF), 1'b1, 32'h0, 1'b0);
    issue(0, mk(1'b0, 4'hF, 32'h20, 32'h0), 1'b0, 32'h11AA3344, 1'b0);
    issue(0, mk(1'b0, 4'h0, 32'h24, 32'h0), 1'b1, 32'h0, 1'b0);
    issue(0, mk(1'b1, 4'hF, 32'hFFC, 32'hA5A5A5A5), 1'b0, 32'h0, 1'b0);
    issue(0, mk(1'b0, 4'hF, 32'hFFC, 32'h0), 1'b0, 32'hA5A5A5A5, 1'b0);

    // Abort: req dropped while waiting; the store must not land.
    issue(0, mk(1'b1, 4'hF, 32'h30, 32'h0BADF00D), 1'b0, 32'h0, 1'b0);
    req_v[0] = 1'b1; we_v[0] = 1'b1; be_v[0] = 4'hF;
    addr_v[0] = 32'h30; wdata_v[0] = 32'h55555555;
    @(posedge clk); #1;
    check("abort_busy_in_wait", {31'b0, busy_v[0]}, 32'd1);
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_dropped", {31'b0, busy_v[0]}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(0, mk(1'b0, 4'hF, 32'h30, 32'h0), 1'b0, 32'h0BADF00D, 1'b0);

    // Reset pulsed mid-wait: outputs clear and the store is discarded.
    req_v[0] = 1'b1; we_v[0] = 1'b1; be_v[0] = 4'hF;
    addr_v[0] = 32'h30; wdata_v[0] = 32'h66666666;
    @(posedge clk); #1;
    check("rst_busy_before", {31'b0, busy_v[0]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'b0, ack_v[0]}, 32'd0);
    check("rst_mid_err", {31'b0, err_v[0]}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_v[0]}, 32'd0);
    check("rst_mid_rdata", rdata_v[0], 32'h0);
    rst = 1'b0; req_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_idle_busy", {31'b0, busy_v[0]}, 32'd0);
    issue(0, mk(1'b0, 4'hF, 32'h30, 32'h0), 1'b0, 32'h0BADF00D, 1'b0);

    // Back-to-back at LATENCY 1 with req held high throughout.
    issue(1, mk(1'b1, 4'hF, 32'h40, 32'hCAFEF00D), 1'b0, 32'h0, 1'b1);
    issue(1, mk(1'b0, 4'hF, 32'h40, 32'h0), 1'b0, 32'hCAFEF00D, 1'b1);
    issue(1, mk(1'b1, 4'b1000, 32'h44, 32'h7F000000), 1'b0, 32'h0, 1'b1);
    issue(1, mk(1'b0, 4'b1000, 32'h44, 32'h0), 1'b0, 32'h7F000000, 1'b0);

    // LATENCY 4 stress against a 16-word model.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      issue(2, mk(1'b1, 4'hF, 32'h100 + 32'(4 * i), model[i]), 1'b0, 32'h0, 1'b0);
    end
    for (int n = 0; n < 100; n++) begin
      idx = $urandom_range(0, 15);
      w   = 1'($urandom_range(0, 1));
      b   = 4'($urandom_range(1, 15));
      d   = $urandom;
      if (w) begin
        issue(2, mk(1'b1, b, 32'h100 + 32'(4 * idx), d), 1'b0, 32'h0, 1'b0);
        model[idx] = (model[idx] & ~lane_mask(b)) | (d & lane_mask(b));
      end else begin
        issue(2, mk(1'b0, b, 32'h100 + 32'(4 * idx), 32'h0), 1'b0,
              model[idx] & lane_mask(b), 1'b0);
      end
    end

    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("scoreboard_drained_i%0d", k), sb[k].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
